avr_dnsz: RTL
=============

# avr_dnsz

Valid/ready width down-converter. It accepts one wide word per handshake on the upstream (m_) port and emits it as RATIO narrow beats on the downstream (s_) port, flagging the final beat of each word. It is the unpacking counterpart of the AVR datapath: it sits wherever a wide AVR stream must feed a narrower AVR consumer. It also acts as a one-word register stage on the data/valid path.

## Interface
- DW_I, 256: upstream word width; must be an integer multiple of RATIO.
- RATIO, 4: narrow beats per wide word; must be ≥1 and a power of two.
- MSB_FIRST, 0: 0 emits slice [DW_O-1:0] first; 1 emits the top slice first.
- DW_O (localparam) = DW_I/RATIO.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m_data  in  DW_I  upstream wide word.
- m_valid  in  1  upstream word valid.
- m_ready  out  1  block can take a wide word this cycle.
- s_data  out  DW_O  current narrow beat.
- s_valid  out  1  narrow beat valid.
- s_last  out  1  high on the final beat of a word; qualified by s_valid.
- s_ready  in  1  downstream accepts the beat.

## Operation
State:
- buf: DW_I word register.
- cnt: beat index, width max(1, clog2(RATIO)).
- full: word held.

Handshakes:
- Upstream handshake: m_valid & m_ready.
- Downstream handshake: s_valid & s_ready.

Outputs:
- s_valid = full.
- s_last = full & (cnt == RATIO-1).
- s_data = buf slice cnt, or slice RATIO-1-cnt when MSB_FIRST=1. Slice k is buf[k*DW_O +: DW_O].
- m_ready = ~rst & (~full | (s_ready & cnt == RATIO-1)).

Update rules, in priority order:
- rst: full←0, cnt←0, buf←0.
- Downstream handshake with cnt < RATIO-1: cnt←cnt+1. buf is unchanged. No upstream handshake is possible in this case.
- Downstream handshake with cnt == RATIO-1:
  - cnt←0.
  - If there is an upstream handshake in the same cycle: buf←m_data, full stays 1.
  - Otherwise: full←0.
- Upstream handshake while empty (full=0): buf←m_data, full←1, cnt←0.
- Otherwise all state holds.

Other rules:
- RATIO=1: cnt is fixed at 0, s_last = s_valid. The block then behaves as a one-entry forward register slice with pass-through refill.
- Beat data, s_last and s_valid are stable while s_valid & ~s_ready (AXI-style hold).
- m_valid may drop without a handshake. m_data is sampled only on an upstream handshake.

## Timing
- Reset values: s_valid=0, s_last=0, s_data=0, m_ready=0 while rst is high. m_ready=1 in the first cycle after rst deasserts.
- Latency: a word accepted at edge t presents its first beat from cycle t+1.
- Throughput: one narrow beat per cycle sustained while s_ready=1. Consecutive words produce no bubble because refill happens on the last-beat edge.
- m_ready is combinational from s_ready (last-beat refill path). s_valid, s_last and s_data come only from registers.
- Reset mid-word: the held word is discarded. No partial beats appear after reset.
- Wrap-around: cnt returns to 0 only on the last-beat handshake. It never overflows.

## Test plan
- DW_I=32, RATIO=4, MSB_FIRST=0, s_ready=1. Send one word 0x44332211 -> s_data = 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, starting 1 cycle after the accept. s_last=1 only with 0x44. s_valid=0 afterwards. m_ready=1 at the end.
- Same config, m_valid=1 continuously with words 0x44332211 then 0x88776655 -> 8 beats 0x11..0x88 in 8 consecutive cycles with no gap. m_ready is high on the cycle 0x44 is emitted, and the second word loads on that edge.
- Backpressure: word 0xDDCCBBAA, with s_ready held 0 for 3 cycles while beat 0xBB is showing -> 0xBB and s_valid held stable for all 3 cycles. m_ready=0 throughout. Remaining beats 0xCC, 0xDD follow once s_ready=1.
- MSB_FIRST=1, word 0x44332211 -> beats 0x44, 0x33, 0x22, 0x11, with s_last on 0x11.
- Reset after beat 0x22 of 0x44332211 has been accepted -> the next cycle shows s_valid=0 and s_last=0. After reset, new word 0xA1A2A3A4 emits 0xA4, 0xA3, 0xA2, 0xA1. No stale 0x33 or 0x44 appears.
- RATIO=1, DW_I=8: stream 0x01, 0x02, 0x03 with random s_ready -> output order is preserved, s_last=s_valid on every beat, and no beat is lost or duplicated.

Source files
------------

// File: rtl/avr_dnsz_if.sv
//------------------------------------------------------------------------------
// Module   : avr_dnsz_if
// Purpose  : Bundles the wide upstream (m_) and narrow downstream (s_) AVR
//            valid/ready signals of the avr_dnsz width down-converter.
// Ports    : m_data/m_valid/m_ready - wide word handshake
//            s_data/s_valid/s_last/s_ready - narrow beat handshake
// Modports : slave  - the converter's view (takes m_, drives s_)
//            master - the environment's view (drives m_, takes s_)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface avr_dnsz_if #(
  parameter int DW_I = 256,
  parameter int DW_O = 64
);
  logic [DW_I-1:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic [DW_O-1:0] s_data;
  logic            s_valid;
  logic            s_last;
  logic            s_ready;

  modport slave (
    input  m_data, m_valid, s_ready,
    output m_ready, s_data, s_valid, s_last
  );

  modport master (
    output m_data, m_valid, s_ready,
    input  m_ready, s_data, s_valid, s_last
  );
endinterface

`default_nettype wire

// File: rtl/avr_dnsz.sv
//------------------------------------------------------------------------------
// Module   : avr_dnsz
// Purpose  : Valid/ready width down-converter. Takes one DW_I-bit word per
//            upstream handshake and emits it as RATIO beats of DW_O bits,
//            flagging the final beat with s_last. Holds at most one word and
//            refills on the last-beat edge, so back-to-back words stream
//            without bubbles.
// Ports    : clk - clock, rising edge
//            rst - synchronous active-high reset
//            bus - avr_dnsz_if.slave (m_data/m_valid/m_ready in,
//                  s_data/s_valid/s_last out, s_ready in)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module avr_dnsz #(
  parameter int DW_I      = 256,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  avr_dnsz_if.slave     bus
);

  localparam int              DW_O = DW_I / RATIO;
  localparam int              CW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0]   LAST = CW'(RATIO - 1);

  logic [DW_I-1:0] buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, full_d;

  logic            w_last;
  logic            w_dn_hs;
  logic            w_up_hs;

  assign w_last  = (cnt_q == LAST);
  assign w_dn_hs = full_q & bus.s_ready;
  // Accept when empty, or when the last beat is leaving this cycle so the
  // next word can load on the same edge.
  assign bus.m_ready = ~rst & (~full_q | (bus.s_ready & w_last));
  assign w_up_hs     = bus.m_valid & bus.m_ready;

  assign bus.s_valid = full_q;
  assign bus.s_last  = full_q & w_last;

  // Beat selection: a static slice table indexed by the (possibly reversed)
  // beat counter.
  generate
    if (RATIO == 1) begin : g_single
      assign bus.s_data = buf_q;
    end else begin : g_multi
      logic [DW_O-1:0] w_slices [RATIO];
      logic [CW-1:0]   w_idx;

      for (genvar k = 0; k < RATIO; k++) begin : g_slice
        assign w_slices[k] = buf_q[k*DW_O +: DW_O];
      end

      if (MSB_FIRST != 0) begin : g_msb_first
        assign w_idx = LAST - cnt_q;
      end else begin : g_lsb_first
        assign w_idx = cnt_q;
      end

      assign bus.s_data = w_slices[w_idx];
    end
  endgenerate

  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (w_dn_hs && !w_last) begin
      // Mid-word beat: m_ready is low here, so no refill can coincide.
      cnt_d = cnt_q + CW'(1);
    end else if (w_dn_hs) begin
      cnt_d = '0;
      if (w_up_hs) begin
        buf_d = bus.m_data;
      end else begin
        full_d = 1'b0;
      end
    end else if (w_up_hs) begin
      buf_d  = bus.m_data;
      full_d = 1'b1;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

endmodule

`default_nettype wire
